// File: rtl/int_ctrl_n.sv
// Interrupt controller: synchronises N_IRQ sources, latches edge/level requests,
// masks them and hands the lowest-index winner to the CPU over Ireq/Iack.
module int_ctrl_n #(
    parameter int unsigned N_IRQ      = 8,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0020,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0008
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq_in,
    output logic             Ireq,
    input  logic             Iack,
    output logic [31:0]      vec_out,
    output logic [4:0]       irq_id,
    output logic             in_service,
    input  logic [1:0]       reg_addr,
    input  logic             reg_wr,
    input  logic [31:0]      reg_wdata,
    output logic [31:0]      reg_rdata
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    localparam logic [4:0]  SPURIOUS_ID  = 5'(N_IRQ);
    localparam logic [31:0] SPURIOUS_VEC = VEC_BASE + 32'(N_IRQ) * VEC_STRIDE;

    logic [N_IRQ-1:0] s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [N_IRQ-1:0] mask_q, mask_d, mode_q, mode_d, pend_q, pend_d;
    logic [1:0]       state_q, state_d;
    logic             ireq_q, ireq_d;
    logic             in_service_q, in_service_d;
    logic [4:0]       irq_id_q, irq_id_d;
    logic [31:0]      vec_q, vec_d;

    logic [N_IRQ-1:0] wdata_n;
    logic [N_IRQ-1:0] req_vec;
    logic [N_IRQ-1:0] win_onehot;
    logic [N_IRQ-1:0] clr_vec;
    logic [N_IRQ-1:0] edge_set;
    logic             win_found;
    logic [4:0]       win_id;
    logic             ack_win;
    logic             wr_mask, wr_mode, wr_pend, wr_stat;
    logic             unused_wdata;

    assign wdata_n      = reg_wdata[N_IRQ-1:0];
    assign unused_wdata = ^reg_wdata;
    assign wr_mask      = reg_wr && (reg_addr == 2'd0);
    assign wr_mode      = reg_wr && (reg_addr == 2'd1);
    assign wr_pend      = reg_wr && (reg_addr == 2'd2);
    assign wr_stat      = reg_wr && (reg_addr == 2'd3);

    assign req_vec  = pend_q & mask_q;
    assign edge_set = s2_q & ~s3_q;

    // Lowest enabled pending index wins; the descending scan leaves it last.
    always_comb begin
        win_found = 1'b0;
        win_id    = 5'd0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (req_vec[i]) begin
                win_found = 1'b1;
                win_id    = 5'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ireq_d       = ireq_q;
        in_service_d = in_service_q;
        irq_id_d     = irq_id_q;
        vec_d        = vec_q;
        ack_win      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d = ST_REQ;
                    ireq_d  = 1'b1;
                end
            end
            ST_REQ: begin
                if (Iack) begin
                    ireq_d = 1'b0;
                    if (win_found) begin
                        state_d      = ST_SERVICE;
                        in_service_d = 1'b1;
                        irq_id_d     = win_id;
                        vec_d        = VEC_BASE + 32'(win_id) * VEC_STRIDE;
                        ack_win      = 1'b1;
                    end else begin
                        state_d  = ST_IDLE;
                        irq_id_d = SPURIOUS_ID;
                        vec_d    = SPURIOUS_VEC;
                    end
                end else if (!win_found) begin
                    state_d = ST_IDLE;
                    ireq_d  = 1'b0;
                end
            end
            ST_SERVICE: begin
                if (wr_stat) begin
                    state_d      = ST_IDLE;
                    in_service_d = 1'b0;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                ireq_d       = 1'b0;
                in_service_d = 1'b0;
            end
        endcase
    end

    // Edge bits latch and a new edge beats any clear; level bits mirror s2.
    always_comb begin
        s1_d       = irq_in;
        s2_d       = s1_q;
        s3_d       = s2_q;
        mask_d     = wr_mask ? wdata_n : mask_q;
        mode_d     = wr_mode ? wdata_n : mode_q;
        win_onehot = ack_win ? (N_IRQ'(1) << win_id) : '0;
        clr_vec    = (wr_pend ? wdata_n : '0) | win_onehot;
        pend_d     = (mode_q & (edge_set | (pend_q & ~clr_vec))) | (~mode_q & s2_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q         <= '0;
            s2_q         <= '0;
            s3_q         <= '0;
            mask_q       <= '0;
            mode_q       <= '0;
            pend_q       <= '0;
            state_q      <= ST_IDLE;
            ireq_q       <= 1'b0;
            in_service_q <= 1'b0;
            irq_id_q     <= 5'd0;
            vec_q        <= VEC_BASE;
        end else begin
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            s3_q         <= s3_d;
            mask_q       <= mask_d;
            mode_q       <= mode_d;
            pend_q       <= pend_d;
            state_q      <= state_d;
            ireq_q       <= ireq_d;
            in_service_q <= in_service_d;
            irq_id_q     <= irq_id_d;
            vec_q        <= vec_d;
        end
    end

    always_comb begin
        reg_rdata = 32'd0;
        case (reg_addr)
            2'd0:    reg_rdata = 32'(mask_q);
            2'd1:    reg_rdata = 32'(mode_q);
            2'd2:    reg_rdata = 32'(pend_q);
            default: reg_rdata = {in_service_q, 26'd0, irq_id_q};
        endcase
    end

    assign Ireq       = ireq_q;
    assign in_service = in_service_q;
    assign irq_id     = irq_id_q;
    assign vec_out    = vec_q;

endmodule

// File: doc/int_ctrl_n.md
# int_ctrl_n

Parametrised interrupt controller between N peripheral interrupt lines and the multi-cycle CPU's single `Ireq`/`Iack` pair. Synchronises sources, latches edge or level requests, applies a software mask, and drives a registered `Ireq` for the highest-priority enabled pending source. On `Iack` it latches the winner and presents its handler vector, then blocks further requests until software writes end-of-interrupt (EOI) over a small register port on the MIO bus.

## Interface
Parameters:
- `N_IRQ`, 8: number of sources, 1..31.
- `VEC_BASE`, 32'h00000020: vector of source 0.
- `VEC_STRIDE`, 32'h00000008: vector spacing per source ID.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-low.
- `irq_in` in N_IRQ: raw asynchronous source lines, active-high.
- `Ireq` out 1: interrupt request to CPU, registered.
- `Iack` in 1: CPU acknowledge, level, sampled on rising `clk`.
- `vec_out` out 32: handler vector of the acknowledged source.
- `irq_id` out 5: ID of the in-service source; `N_IRQ` = spurious.
- `in_service` out 1: high from accepted `Iack` until EOI.
- `reg_addr` in 2: register select.
- `reg_wr` in 1: register write strobe, one cycle.
- `reg_wdata` in 32: write data; bits above N_IRQ-1 ignored.
- `reg_rdata` out 32: combinational read data; unused bits 0.

## Operation
- Each `irq_in[i]` passes a 2-flop synchroniser (`s1`,`s2`), then a history flop `s3`.
- Registers:
  - 0 MASK, RW, 1 = enabled, reset 0.
  - 1 MODE, RW, 1 = edge, 0 = level, reset 0.
  - 2 PEND, read; a write clears edge bits where `reg_wdata` = 1.
  - 3 STAT, reads {in_service at bit 31, irq_id[4:0]}; any write = EOI.
- Pending bit i:
  - Edge mode: set on `s2 & ~s3`, held until acknowledged or cleared. A set and a clear in the same cycle leave the bit set.
  - Level mode: equals `s2`, with no latching.
  - Masking never clears a pending bit; it only blocks requests.
- Winner: lowest index i with PEND[i] & MASK[i].
- State machine, reset to IDLE:
  - IDLE: a winner exists -> REQ, `Ireq` <= 1.
  - REQ: `Iack` with a winner -> SERVICE. On that edge:
    - latch `irq_id` = winner;
    - `vec_out` = VEC_BASE + winner*VEC_STRIDE (32-bit, modulo 2^32);
    - clear the winner's edge-pending bit;
    - `Ireq` <= 0, `in_service` <= 1.
  - REQ: `Iack` with no winner (request withdrawn in the same cycle) -> IDLE. Set `irq_id` = N_IRQ, `vec_out` = VEC_BASE + N_IRQ*VEC_STRIDE, `Ireq` <= 0, `in_service` stays 0.
  - REQ: no `Iack` and the winner vanishes (level drop, mask, or PEND clear) -> IDLE, `Ireq` <= 0.
  - SERVICE: `Iack` is ignored and new pendings accumulate. An EOI write -> IDLE, `in_service` <= 0. `irq_id` and `vec_out` hold until the next acknowledge.
  - EOI in IDLE or REQ has no effect.
- No nesting: only one source is in service at a time.
- `reset` asserted mid-operation clears all state, pending bits, and registers immediately.

## Timing
- Reset values: `Ireq`=0, `in_service`=0, `irq_id`=0, `vec_out`=VEC_BASE, MASK=MODE=PEND=0, synchronisers 0.
- Edge source, already enabled, rising before edge k:
  - PEND set after edge k+2;
  - `Ireq` high after edge k+3.
- Level source: `Ireq` high after edge k+3 as well.
- `Iack` sampled high at edge a: after edge a, `Ireq`=0, `vec_out`/`irq_id` valid, `in_service`=1.
- EOI write at edge e: IDLE after e. If a request is still pending, `Ireq` rises again after e+1.
- MASK/MODE writes take effect for the winner computation in the cycle after the write edge.
- `reg_rdata` reflects register state combinationally, with no read side effects.

## Test plan
- Reset: hold `reset`=0 for 3 cycles with `irq_in`=8'hFF -> `Ireq`=0, `vec_out`=32'h20, all registers read 0.
- Edge request: MASK=8'h08, MODE=8'h08, pulse `irq_in[3]` for 1 cycle -> `Ireq` high 4 cycles later. `Iack` pulse -> `irq_id`=3, `vec_out`=32'h38, PEND=0. EOI -> `in_service`=0, `Ireq` stays 0.
- Priority: MASK=8'hFF, MODE=8'hFF, edges on sources 5 and 2 together. First `Iack` -> `irq_id`=2. After EOI, `Ireq` rises again; second `Iack` -> `irq_id`=5, `vec_out`=32'h48.
- Level withdrawal: MODE=0, `irq_in[1]` high until `Ireq`=1, then dropped. `Ireq` -> 0 within 3 cycles. `Iack` in the cycle the winner vanishes -> `irq_id`=8, `vec_out`=32'h60, `in_service`=0.
- Masked latching: MASK=0, MODE=8'h01, edge on source 0 -> PEND=8'h01, `Ireq`=0. Set MASK=8'h01 -> `Ireq` high 2 edges after the write. Write PEND=8'h01 on the same cycle as a new edge -> the bit stays set.
- Reset during SERVICE: assert `reset` -> `in_service`, `Ireq`, and PEND all 0 immediately (asynchronously); `Iack` is ignored until release.
